// File: rtl/mouse_init_sequencer.sv
// PS/2 mouse bring-up sequencer: reset the mouse (0xFF), check FA/AA/00, enable
// streaming (0xF4), check FA, then hand the byte stream to the packet decoder.
module mouse_init_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       RESTART,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic       INIT_DONE,
    output logic       INIT_FAIL,
    output logic [3:0] RETRY_COUNT,
    output logic [3:0] STATE_OUT
);

    localparam int          TW           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        SEND_RST    = 4'd1,
        WAIT_TX_RST = 4'd2,
        WAIT_ACK1   = 4'd3,
        WAIT_AA     = 4'd4,
        WAIT_ID     = 4'd5,
        SEND_EN     = 4'd6,
        WAIT_TX_EN  = 4'd7,
        WAIT_ACK2   = 4'd8,
        STREAM      = 4'd9,
        FAIL        = 4'd10
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q;
    logic [3:0]      retry_d;
    logic            in_wait, expired, attempt_fail;
    logic [7:0]      want_byte;
    state_t          pass_state;

    assign in_wait = (state_q == WAIT_TX_RST) || (state_q == WAIT_ACK1) || (state_q == WAIT_AA) ||
                     (state_q == WAIT_ID)     || (state_q == WAIT_TX_EN) || (state_q == WAIT_ACK2);
    assign expired = in_wait && (timer_q == TIMEOUT_LAST);

    // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        retry_d      = RETRY_COUNT;
        attempt_fail = 1'b0;
        want_byte    = 8'hFA;
        pass_state   = STREAM;

        case (state_q)
            WAIT_ACK1: begin want_byte = 8'hFA; pass_state = WAIT_AA;  end
            WAIT_AA:   begin want_byte = 8'hAA; pass_state = WAIT_ID;  end
            WAIT_ID:   begin want_byte = 8'h00; pass_state = SEND_EN;  end
            default:   begin want_byte = 8'hFA; pass_state = STREAM;   end
        endcase

        case (state_q)
            IDLE:        state_d = SEND_RST;
            SEND_RST:    state_d = WAIT_TX_RST;
            SEND_EN:     state_d = WAIT_TX_EN;
            // The transmitter cannot abort a byte, so a stuck send is fatal rather than retried.
            WAIT_TX_RST: if (BYTE_SENT) state_d = WAIT_ACK1; else if (expired) state_d = FAIL;
            WAIT_TX_EN:  if (BYTE_SENT) state_d = WAIT_ACK2; else if (expired) state_d = FAIL;
            WAIT_ACK1, WAIT_AA, WAIT_ID, WAIT_ACK2: begin
                if (BYTE_READY) begin
                    if (BYTE_ERROR_CODE == 2'd0 && BYTE_READ == want_byte) state_d = pass_state;
                    else attempt_fail = 1'b1;
                end else if (expired) begin
                    attempt_fail = 1'b1;
                end
            end
            STREAM, FAIL: state_d = state_q;
            default:      state_d = IDLE;
        endcase

        if (attempt_fail) begin
            retry_d = (RETRY_COUNT == 4'd15) ? 4'd15 : RETRY_COUNT + 4'd1;
            state_d = (retry_d == RETRY_LIMIT) ? FAIL : SEND_RST;
        end

        if (RESTART) begin
            state_d = SEND_RST;
            retry_d = 4'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            RETRY_COUNT  <= 4'd0;
            SEND_BYTE    <= 1'b0;
            BYTE_TO_SEND <= 8'h00;
            READ_ENABLE  <= 1'b0;
            INIT_DONE    <= 1'b0;
            INIT_FAIL    <= 1'b0;
        end else begin
            state_q     <= state_d;
            RETRY_COUNT <= retry_d;
            if (state_d != state_q || !in_wait) timer_q <= '0;
            else                                timer_q <= timer_q + TW'(1);

            // Outputs are decoded from the next state so they line up with the registered state.
            SEND_BYTE   <= (state_d == SEND_RST) || (state_d == SEND_EN);
            if (state_d == SEND_RST)     BYTE_TO_SEND <= 8'hFF;
            else if (state_d == SEND_EN) BYTE_TO_SEND <= 8'hF4;
            READ_ENABLE <= (state_d == WAIT_ACK1) || (state_d == WAIT_AA) || (state_d == WAIT_ID) ||
                           (state_d == WAIT_ACK2) || (state_d == STREAM);
            INIT_DONE   <= (state_d == STREAM);
            INIT_FAIL   <= (state_d == FAIL);
        end
    end

    assign STATE_OUT = state_q;

endmodule

// File: tb/tb_mouse_init_sequencer.sv
// Directed bench for mouse_init_sequencer: nominal bring-up, retries, timeouts,
// event races, RESTART and mid-sequence reset, with hand-computed expectations.
module tb_mouse_init_sequencer;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       RESTART = 1'b0;
    logic       BYTE_SENT = 1'b0;
    logic       BYTE_READY = 1'b0;
    logic [7:0] BYTE_READ = 8'h00;
    logic [1:0] BYTE_ERROR_CODE = 2'd0;
    logic       SEND_BYTE, READ_ENABLE, INIT_DONE, INIT_FAIL;
    logic [7:0] BYTE_TO_SEND;
    logic [3:0] RETRY_COUNT, STATE_OUT;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         send_count = 0;
    int         base = 0;
    logic [7:0] sent_q[$];
    logic [7:0] b0, b1;

    mouse_init_sequencer #(.TIMEOUT_CYCLES(1000), .MAX_RETRIES(3)) dut (
        .CLK(CLK), .RESETN(RESETN), .RESTART(RESTART),
        .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND), .BYTE_SENT(BYTE_SENT),
        .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ), .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
        .BYTE_READY(BYTE_READY), .INIT_DONE(INIT_DONE), .INIT_FAIL(INIT_FAIL),
        .RETRY_COUNT(RETRY_COUNT), .STATE_OUT(STATE_OUT)
    );

    always #5 CLK = ~CLK;

    // Transmit-side monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        if (SEND_BYTE === 1'b1) begin
            send_count++;
            sent_q.push_back(BYTE_TO_SEND);
        end
    end

    // NOTE: inputs are driven with blocking assignments 1 time unit after the rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulse_sent;
        BYTE_SENT = 1'b1;
        tick();
        BYTE_SENT = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b, input logic [1:0] e);
        BYTE_READ = b;
        BYTE_ERROR_CODE = e;
        BYTE_READY = 1'b1;
        tick();
        BYTE_READY = 1'b0;
        BYTE_READ = 8'h00;
        BYTE_ERROR_CODE = 2'd0;
    endtask

    task automatic pulse_restart;
        RESTART = 1'b1;
        tick();
        RESTART = 1'b0;
    endtask

    task automatic do_reset;
        RESETN = 1'b0;
        tick();
        RESETN = 1'b1;
        base = send_count;
    endtask

    task automatic to_ack1;
        do_reset();
        tick(2);
        pulse_sent();
    endtask

    task automatic test_reset;
        RESETN = 1'b0;
        tick(2);
        n_cmp++; if (STATE_OUT !== 4'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", STATE_OUT); end
        n_cmp++; if (SEND_BYTE !== 1'b0) begin n_bad++; $display("FAIL reset_send: got %b want 0", SEND_BYTE); end
        n_cmp++; if (BYTE_TO_SEND !== 8'h00) begin n_bad++; $display("FAIL reset_byte: got %h want 00", BYTE_TO_SEND); end
        n_cmp++; if (READ_ENABLE !== 1'b0) begin n_bad++; $display("FAIL reset_rden: got %b want 0", READ_ENABLE); end
        n_cmp++; if (INIT_DONE !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", INIT_DONE); end
        n_cmp++; if (INIT_FAIL !== 1'b0) begin n_bad++; $display("FAIL reset_fail: got %b want 0", INIT_FAIL); end
        n_cmp++; if (RETRY_COUNT !== 4'd0) begin n_bad++; $display("FAIL reset_retry: got %0d want 0", RETRY_COUNT); end
        RESETN = 1'b1;
        base = send_count;
        tick();
        n_cmp++; if (STATE_OUT !== 4'd1) begin n_bad++; $display("FAIL release_state: got %0d want 1", STATE_OUT); end
        n_cmp++; if (SEND_BYTE !== 1'b1) begin n_bad++; $display("FAIL release_send: got %b want 1", SEND_BYTE); end
        n_cmp++; if (BYTE_TO_SEND !== 8'hFF) begin n_bad++; $display("FAIL release_byte: got %h want ff", BYTE_TO_SEND); end
        tick();
        n_cmp++; if (STATE_OUT !== 4'd2) begin n_bad++; $display("FAIL release_wait_tx: got %0d want 2", STATE_OUT); end
        n_cmp++; if (SEND_BYTE !== 1'b0) begin n_bad++; $display("FAIL send_one_cycle: got %b want 0", SEND_BYTE); end
    endtask

    task automatic test_nominal;
        do_reset();
        tick();
        n_cmp++; if (SEND_BYTE !== 1'b1 || BYTE_TO_SEND !== 8'hFF) begin n_bad++; $display("FAIL nom_send_ff: got %b/%h want 1/ff", SEND_BYTE, BYTE_TO_SEND); end
        tick(49);
        n_cmp++; if (BYTE_TO_SEND !== 8'hFF || READ_ENABLE !== 1'b0) begin n_bad++; $display("FAIL nom_hold_ff: got %h/%b want ff/0", BYTE_TO_SEND, READ_ENABLE); end
        pulse_sent();
        n_cmp++; if (STATE_OUT !== 4'd3 || READ_ENABLE !== 1'b1) begin n_bad++; $display("FAIL nom_ack1: got %0d/%b want 3/1", STATE_OUT, READ_ENABLE); end
        tick(5);
        rx(8'hFA, 2'd0);
        rx(8'hAA, 2'd0);
        tick(3);
        rx(8'h00, 2'd0);
        n_cmp++; if (STATE_OUT !== 4'd6 || SEND_BYTE !== 1'b1 || BYTE_TO_SEND !== 8'hF4 || READ_ENABLE !== 1'b0) begin
            n_bad++; $display("FAIL nom_send_en: got st=%0d sb=%b b=%h re=%b want 6/1/f4/0", STATE_OUT, SEND_BYTE, BYTE_TO_SEND, READ_ENABLE);
        end
        tick(49);
        n_cmp++; if (STATE_OUT !== 4'd7 || BYTE_TO_SEND !== 8'hF4) begin n_bad++; $display("FAIL nom_wait_tx_en: got %0d/%h want 7/f4", STATE_OUT, BYTE_TO_SEND); end
        pulse_sent();
        n_cmp++; if (STATE_OUT !== 4'd8 || INIT_DONE !== 1'b0) begin n_bad++; $display("FAIL nom_ack2: got %0d/%b want 8/0", STATE_OUT, INIT_DONE); end
        rx(8'hFA, 2'd0);
        n_cmp++; if (INIT_DONE !== 1'b1) begin n_bad++; $display("FAIL nom_done_latency: got %b want 1", INIT_DONE); end
        n_cmp++; if (STATE_OUT !== 4'd9) begin n_bad++; $display("FAIL nom_stream: got %0d want 9", STATE_OUT); end
        n_cmp++; if (RETRY_COUNT !== 4'd0) begin n_bad++; $display("FAIL nom_retry: got %0d want 0", RETRY_COUNT); end
        n_cmp++; if (send_count - base !== 2) begin n_bad++; $display("FAIL nom_send_count: got %0d want 2", send_count - base); end
        b0 = (sent_q.size() > base) ? sent_q[base] : 8'hxx;
        b1 = (sent_q.size() > base + 1) ? sent_q[base + 1] : 8'hxx;
        n_cmp++; if (b0 !== 8'hFF || b1 !== 8'hF4) begin n_bad++; $display("FAIL nom_send_bytes: got %h %h want ff f4", b0, b1); end
        rx(8'h33, 2'd1);
        tick(1050);
        n_cmp++; if (STATE_OUT !== 4'd9 || INIT_DONE !== 1'b1 || RETRY_COUNT !== 4'd0) begin
            n_bad++; $display("FAIL nom_stream_hold: got %0d/%b/%0d want 9/1/0", STATE_OUT, INIT_DONE, RETRY_COUNT);
        end
    endtask

    task automatic test_wrong_id;
        to_ack1();
        rx(8'hFA, 2'd0);
        rx(8'hAA, 2'd0);
        rx(8'h03, 2'd0);
        n_cmp++; if (STATE_OUT !== 4'd1 || RETRY_COUNT !== 4'd1) begin n_bad++; $display("FAIL wid_retry: got %0d/%0d want 1/1", STATE_OUT, RETRY_COUNT); end
        n_cmp++; if (SEND_BYTE !== 1'b1 || BYTE_TO_SEND !== 8'hFF) begin n_bad++; $display("FAIL wid_resend: got %b/%h want 1/ff", SEND_BYTE, BYTE_TO_SEND); end
        tick();
        pulse_sent();
        rx(8'hFA, 2'd0);
        rx(8'hAA, 2'd0);
        rx(8'h00, 2'd0);
        tick();
        pulse_sent();
        rx(8'hFA, 2'd0);
        n_cmp++; if (INIT_DONE !== 1'b1 || RETRY_COUNT !== 4'd1) begin n_bad++; $display("FAIL wid_done: got %b/%0d want 1/1", INIT_DONE, RETRY_COUNT); end
        n_cmp++; if (send_count - base !== 3) begin n_bad++; $display("FAIL wid_send_count: got %0d want 3", send_count - base); end
    endtask

    task automatic test_restart_from_stream;
        pulse_restart();
        n_cmp++; if (INIT_DONE !== 1'b0) begin n_bad++; $display("FAIL rst_done_drop: got %b want 0", INIT_DONE); end
        n_cmp++; if (STATE_OUT !== 4'd1 || SEND_BYTE !== 1'b1 || BYTE_TO_SEND !== 8'hFF) begin
            n_bad++; $display("FAIL rst_resend: got %0d/%b/%h want 1/1/ff", STATE_OUT, SEND_BYTE, BYTE_TO_SEND);
        end
        n_cmp++; if (RETRY_COUNT !== 4'd0) begin n_bad++; $display("FAIL rst_retry_clr: got %0d want 0", RETRY_COUNT); end
    endtask

    task automatic test_silent_mouse;
        to_ack1();
        for (int a = 1; a <= 3; a++) begin
            tick(999);
            n_cmp++; if (STATE_OUT !== 4'd3) begin n_bad++; $display("FAIL sil_before_expiry%0d: got %0d want 3", a, STATE_OUT); end
            tick();
            n_cmp++; if (RETRY_COUNT !== 4'(a)) begin n_bad++; $display("FAIL sil_retry%0d: got %0d want %0d", a, RETRY_COUNT, a); end
            if (a < 3) begin
                n_cmp++; if (STATE_OUT !== 4'd1) begin n_bad++; $display("FAIL sil_resend%0d: got %0d want 1", a, STATE_OUT); end
                tick();
                pulse_sent();
            end
        end
        n_cmp++; if (STATE_OUT !== 4'd10 || INIT_FAIL !== 1'b1 || INIT_DONE !== 1'b0 || READ_ENABLE !== 1'b0) begin
            n_bad++; $display("FAIL sil_fail: got st=%0d f=%b d=%b re=%b want 10/1/0/0", STATE_OUT, INIT_FAIL, INIT_DONE, READ_ENABLE);
        end
        tick(20);
        n_cmp++; if (send_count - base !== 3 || STATE_OUT !== 4'd10) begin n_bad++; $display("FAIL sil_sticky: got sends=%0d st=%0d want 3/10", send_count - base, STATE_OUT); end
        pulse_restart();
        n_cmp++; if (STATE_OUT !== 4'd1 || RETRY_COUNT !== 4'd0 || INIT_FAIL !== 1'b0) begin
            n_bad++; $display("FAIL sil_restart: got %0d/%0d/%b want 1/0/0", STATE_OUT, RETRY_COUNT, INIT_FAIL);
        end
    endtask

    task automatic test_stuck_tx;
        do_reset();
        tick(2);
        tick(999);
        n_cmp++; if (STATE_OUT !== 4'd2) begin n_bad++; $display("FAIL stuck_before_expiry: got %0d want 2", STATE_OUT); end
        tick();
        n_cmp++; if (STATE_OUT !== 4'd10 || INIT_FAIL !== 1'b1 || RETRY_COUNT !== 4'd0) begin
            n_bad++; $display("FAIL stuck_fail: got %0d/%b/%0d want 10/1/0", STATE_OUT, INIT_FAIL, RETRY_COUNT);
        end
        tick(20);
        n_cmp++; if (send_count - base !== 1) begin n_bad++; $display("FAIL stuck_no_resend: got %0d want 1", send_count - base); end
    endtask

    task automatic test_races;
        to_ack1();
        tick(999);
        rx(8'hFA, 2'd0);
        n_cmp++; if (STATE_OUT !== 4'd4 || RETRY_COUNT !== 4'd0) begin n_bad++; $display("FAIL race_ready_vs_timeout: got %0d/%0d want 4/0", STATE_OUT, RETRY_COUNT); end
        to_ack1();
        rx(8'hFA, 2'd2);
        n_cmp++; if (STATE_OUT !== 4'd1 || RETRY_COUNT !== 4'd1) begin n_bad++; $display("FAIL race_err_code: got %0d/%0d want 1/1", STATE_OUT, RETRY_COUNT); end
        do_reset();
        tick(2);
        tick(999);
        pulse_sent();
        n_cmp++; if (STATE_OUT !== 4'd3 || INIT_FAIL !== 1'b0) begin n_bad++; $display("FAIL race_sent_vs_timeout: got %0d/%b want 3/0", STATE_OUT, INIT_FAIL); end
        do_reset();
        tick(2);
        rx(8'h00, 2'd3);
        rx(8'hFA, 2'd0);
        n_cmp++; if (STATE_OUT !== 4'd2 || RETRY_COUNT !== 4'd0) begin n_bad++; $display("FAIL ready_ignored_tx: got %0d/%0d want 2/0", STATE_OUT, RETRY_COUNT); end
    endtask

    task automatic test_reset_mid;
        to_ack1();
        rx(8'h55, 2'd0);
        tick();
        pulse_sent();
        rx(8'hFA, 2'd0);
        n_cmp++; if (STATE_OUT !== 4'd4 || RETRY_COUNT !== 4'd1) begin n_bad++; $display("FAIL mid_setup: got %0d/%0d want 4/1", STATE_OUT, RETRY_COUNT); end
        RESETN = 1'b0;
        tick();
        RESETN = 1'b1;
        n_cmp++; if (STATE_OUT !== 4'd0 || SEND_BYTE !== 1'b0 || BYTE_TO_SEND !== 8'h00 || READ_ENABLE !== 1'b0 ||
                     INIT_DONE !== 1'b0 || INIT_FAIL !== 1'b0 || RETRY_COUNT !== 4'd0) begin
            n_bad++; $display("FAIL mid_reset_values: got st=%0d sb=%b b=%h re=%b d=%b f=%b r=%0d want all zero",
                              STATE_OUT, SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, INIT_DONE, INIT_FAIL, RETRY_COUNT);
        end
        tick();
        n_cmp++; if (SEND_BYTE !== 1'b1 || STATE_OUT !== 4'd1) begin n_bad++; $display("FAIL mid_release_send: got %b/%0d want 1/1", SEND_BYTE, STATE_OUT); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_wrong_id();
        test_restart_from_stream();
        test_silent_mouse();
        test_stuck_tx();
        test_races();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
